// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial-pattern recognizer.
package seq_det_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int LEN_W_DEF   = 4;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic len_ok(input logic [31:0] len, input logic [31:0] max_len);
    return (len != 32'd0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Window shift register, fill counter and length-masked pattern compare.
module seq_match_core #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en,
  input  logic               clear,
  input  logic               x,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] pattern,
  output logic               hit,
  output logic               full
);

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] win_next;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill;

  // hit and full look at the window including the bit being shifted in now
  assign win_next = {window[MAX_LEN-2:0], x};
  assign hit      = ((win_next ^ pattern) & mask) == '0;
  assign full     = ({1'b0, fill} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, len};

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window <= '0;
      fill   <= '0;
    end else if (clear) begin
      window <= '0;
      fill   <= '0;
    end else if (shift_en) begin
      window <= win_next;
      if (fill != LEN_W'(MAX_LEN)) begin
        fill <= fill + {{(LEN_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for the programmable recognizer: config port, FSM, match counter.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  output logic               cfg_err,
  input  logic               start,
  input  logic               abort,
  input  logic               x,
  input  logic               x_valid,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done
);

  state_t             state, state_n;
  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic [CNT_W-1:0]   tgt_r;
  logic               cfg_ok;
  logic [CNT_W-1:0]   cnt_inc;

  logic start_ok, cfg_acc, cfg_legal, run_start;
  logic shift_en, core_clear, match;
  logic hit, full;

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .clear    (core_clear),
    .x        (x),
    .len      (len_r),
    .pattern  (pat_r),
    .hit      (hit),
    .full     (full)
  );

  assign cfg_ready = (state == IDLE) || (state == DONE);
  assign busy      = (state == FILL) || (state == RUN);
  assign done      = (state == DONE);
  assign cfg_legal = len_ok(32'(cfg_len), 32'(MAX_LEN));
  assign cnt_inc   = (match_cnt == '1) ? match_cnt : match_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign start_ok  = start && (((state == IDLE) && cfg_ok) || (state == DONE));

  // Priority: abort > start > config handshake > serial bit
  always_comb begin
    state_n    = state;
    core_clear = 1'b0;
    shift_en   = 1'b0;
    cfg_acc    = 1'b0;
    match      = 1'b0;
    run_start  = 1'b0;
    if (abort) begin
      state_n    = IDLE;
      core_clear = 1'b1;
    end else if (start_ok) begin
      state_n    = FILL;
      core_clear = 1'b1;
      run_start  = 1'b1;
    end else if (cfg_valid && cfg_ready) begin
      cfg_acc = 1'b1;
      state_n = IDLE;
    end else if (x_valid && ((state == FILL) || (state == RUN))) begin
      shift_en = 1'b1;
      if (state == RUN) begin
        match = hit;
      end else begin
        match = hit && full;
        if (full) state_n = RUN;
      end
      if (match && (tgt_r != '0) && (cnt_inc == tgt_r)) state_n = DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pat_r     <= '0;
      len_r     <= '0;
      tgt_r     <= '0;
      cfg_ok    <= 1'b0;
      cfg_err   <= 1'b0;
      y         <= 1'b0;
      match_cnt <= '0;
    end else begin
      state   <= state_n;
      y       <= match;
      cfg_err <= cfg_acc && !cfg_legal;
      if (cfg_acc && cfg_legal) begin
        pat_r  <= cfg_pattern;
        len_r  <= cfg_len;
        tgt_r  <= cfg_target;
        cfg_ok <= 1'b1;
      end
      if (run_start) begin
        match_cnt <= '0;
      end else if (match) begin
        match_cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl with hand-computed expected y / counter values.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic [7:0] cfg_target = '0;
  logic       cfg_err;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       y;
  logic [7:0] match_cnt;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  seq_det_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_target  (cfg_target),
    .cfg_err     (cfg_err),
    .start       (start),
    .abort       (abort),
    .x           (x),
    .x_valid     (x_valid),
    .y           (y),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock; sampling happens 1ns after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] tgt);
    cfg_valid   = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_target  = tgt;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  // bits[0] is sent first; yexp[i] is the y expected right after bit i
  task automatic run_bits(input string name, input logic [15:0] bits, input int n,
                          input logic [15:0] yexp, input logic gap);
    for (int i = 0; i < n; i++) begin
      x       = bits[i];
      x_valid = 1'b1;
      cyc();
      x_valid = 1'b0;
      check($sformatf("%s_y%0d", name, i + 1), 32'(y), 32'(yexp[i]));
      if (gap) begin
        x = ~bits[i];
        cyc();
        check($sformatf("%s_gap%0d", name, i + 1), 32'(y), 32'd0);
      end
    end
  endtask

  initial begin
    cyc();
    cyc();
    check("rst_y", 32'(y), 0);
    check("rst_cnt", 32'(match_cnt), 0);
    check("rst_err", 32'(cfg_err), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(cfg_ready), 1);
    rst = 1'b0;
    cyc();

    // illegal configs before any legal one; start must be ignored
    do_cfg(8'b101, 4'd0, 8'd0);
    check("len0_err", 32'(cfg_err), 1);
    cyc();
    check("len0_err_clr", 32'(cfg_err), 0);
    do_cfg(8'b101, 4'd9, 8'd0);
    check("len9_err", 32'(cfg_err), 1);
    do_start();
    check("nocfg_busy", 32'(busy), 0);

    // 1: single match in a longer stream
    do_cfg(8'b101, 4'd3, 8'd0);
    check("cfg_ok_err", 32'(cfg_err), 0);
    do_start();
    check("t1_busy", 32'(busy), 1);
    run_bits("t1", 16'b1100_1101_1110, 12, 16'b0000_0100_0000, 1'b0);
    check("t1_cnt", 32'(match_cnt), 1);

    // 2: overlapping matches; abort holds the count
    do_abort();
    check("abort_cnt_hold", 32'(match_cnt), 1);
    check("abort_busy", 32'(busy), 0);
    do_start();
    check("t2_cnt_clr", 32'(match_cnt), 0);
    run_bits("t2", 16'b10101, 5, 16'b10100, 1'b0);
    check("t2_cnt", 32'(match_cnt), 2);

    // 3: target reached -> DONE, later bits ignored
    do_abort();
    do_cfg(8'b101, 4'd3, 8'd2);
    do_start();
    run_bits("t3", 16'b1010101, 7, 16'b0010100, 1'b0);
    check("t3_cnt", 32'(match_cnt), 2);
    check("t3_done", 32'(done), 1);
    check("t3_ready", 32'(cfg_ready), 1);
    check("t3_busy", 32'(busy), 0);

    // 4: config from DONE goes to IDLE; sparse x_valid
    do_cfg(8'b1101, 4'd4, 8'd0);
    check("t4_done_clr", 32'(done), 0);
    check("t4_ready", 32'(cfg_ready), 1);
    do_start();
    run_bits("t4", 16'b1011011, 7, 16'b1001000, 1'b1);
    check("t4_cnt", 32'(match_cnt), 2);

    // 5: abort mid-fill must not leave stale window bits
    do_abort();
    do_cfg(8'b101, 4'd3, 8'd0);
    do_start();
    run_bits("t5a", 16'b01, 2, 16'b00, 1'b0);
    do_abort();
    check("t5_busy", 32'(busy), 0);
    do_start();
    run_bits("t5b", 16'b101, 3, 16'b100, 1'b0);

    // len=1: every matching bit pulses y
    do_abort();
    do_cfg(8'b1, 4'd1, 8'd0);
    do_start();
    run_bits("len1", 16'b101, 3, 16'b101, 1'b0);
    check("len1_cnt", 32'(match_cnt), 2);

    // 6: async reset loses config; config while busy is refused
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_cnt", 32'(match_cnt), 0);
    cyc();
    rst = 1'b0;
    do_start();
    check("arst_nocfg", 32'(busy), 0);
    do_cfg(8'b101, 4'd3, 8'd0);
    do_start();
    check("t6_ready_busy", 32'(cfg_ready), 0);
    do_cfg(8'b11, 4'd2, 8'd0);
    check("t6_noerr", 32'(cfg_err), 0);
    run_bits("t6", 16'b101, 3, 16'b100, 1'b0);
    check("t6_cnt", 32'(match_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
